// File: rtl/w5300_bus_ctrl.sv
// W5300 16-bit direct-mode host bus master: one request in, one timed CSn/RDn/WRn cycle out.
// Latency: accept-to-rspValid = SETUP_CYCLES + RD/WR_CYCLES + 1 clk; next accept IDLE_CYCLES + 1 later.
// Backpressure: reqReady is high only in IDLE; requests offered while busy are ignored, not queued.
// Optional feature: define W5300_ADDR_CHECK_EN to reject odd addresses without a bus cycle.
module w5300_bus_ctrl #(
  parameter int SETUP_CYCLES = 1,
  parameter int RD_CYCLES    = 7,
  parameter int WR_CYCLES    = 6,
  parameter int IDLE_CYCLES  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqOp,
  input  logic [9:0]  reqAddr,
  input  logic [15:0] reqWdata,
  output logic        rspValid,
  output logic [15:0] rspRdata,
  output logic        rspErr,
  output logic        busy,
  output logic [9:0]  w5300Addr,
  output logic [15:0] w5300DataOut,
  output logic        w5300DataOe,
  input  logic [15:0] w5300DataIn,
  output logic        w5300CsN,
  output logic        w5300RdN,
  output logic        w5300WrN
);

  localparam int MAX_AB = (SETUP_CYCLES > RD_CYCLES) ? SETUP_CYCLES : RD_CYCLES;
  localparam int MAX_CD = (WR_CYCLES > IDLE_CYCLES) ? WR_CYCLES : IDLE_CYCLES;
  localparam int MAX_CY = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W  = (MAX_CY < 1) ? 1 : $clog2(MAX_CY + 1);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LD    = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LD    = CNT_W'(WR_CYCLES - 1);
  localparam logic [CNT_W-1:0] IDLE_LD  = CNT_W'(IDLE_CYCLES - 1);

  localparam logic OP_RD = 1'b1;

  // Every phase must last at least one clock, otherwise the counter underflows.
  if (SETUP_CYCLES < 1 || RD_CYCLES < 1 || WR_CYCLES < 1 || IDLE_CYCLES < 1) begin : g_param_err
    $error("w5300_bus_ctrl: SETUP/RD/WR/IDLE_CYCLES must all be >= 1");
  end

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              err_q, err_d;
  logic [9:0]        addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              cs_n_q, cs_n_d;
  logic              rd_n_q, rd_n_d;
  logic              wr_n_q, wr_n_d;
  logic              oe_q, oe_d;
  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [15:0]       rsp_rdata_q, rsp_rdata_d;
  logic              accept;
  logic              bus_active;
  logic              cnt_zero;

  // Next-state, counter and latched-request logic; outputs are derived from the next state
  // so that every pin comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    accept      = (state_q == ST_IDLE) && req_ready_q && reqValid;
    cnt_zero    = (cnt_q == '0);

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = reqOp;
          addr_d  = reqAddr;
          wdata_d = reqWdata;
`ifdef W5300_ADDR_CHECK_EN
          err_d   = reqAddr[0];
`else
          err_d   = 1'b0;
`endif
          if (err_d) begin
            state_d     = ST_HOLD;
            rsp_rdata_d = '0;
          end else begin
            state_d = ST_SETUP;
            cnt_d   = SETUP_LD;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          state_d = ST_STROBE;
          cnt_d   = (op_q == OP_RD) ? RD_LD : WR_LD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_zero) begin
          state_d     = ST_HOLD;
          // Read data is sampled on the edge that ends the strobe, while RDn is still low.
          rsp_rdata_d = (op_q == OP_RD) ? w5300DataIn : 16'h0000;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        state_d = ST_RECOVER;
        cnt_d   = IDLE_LD;
      end
      ST_RECOVER: begin
        if (cnt_zero) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A rejected access passes through HOLD with the chip never selected.
    bus_active  = ((state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD)) && !err_d;
    cs_n_d      = !bus_active;
    rd_n_d      = !((state_d == ST_STROBE) && (op_d == OP_RD));
    wr_n_d      = !((state_d == ST_STROBE) && (op_d != OP_RD));
    oe_d        = bus_active && (op_d != OP_RD);
    req_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    rsp_valid_d = (state_d == ST_HOLD);
    rsp_err_d   = (state_d == ST_HOLD) && err_d;
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cs_n_q      <= 1'b1;
      rd_n_q      <= 1'b1;
      wr_n_q      <= 1'b1;
      oe_q        <= 1'b0;
      req_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cs_n_q      <= cs_n_d;
      rd_n_q      <= rd_n_d;
      wr_n_q      <= wr_n_d;
      oe_q        <= oe_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign reqReady     = req_ready_q;
  assign rspValid     = rsp_valid_q;
  assign rspRdata     = rsp_rdata_q;
  assign rspErr       = rsp_err_q;
  assign busy         = busy_q;
  assign w5300Addr    = addr_q;
  assign w5300DataOut = wdata_q;
  assign w5300DataOe  = oe_q;
  assign w5300CsN     = cs_n_q;
  assign w5300RdN     = rd_n_q;
  assign w5300WrN     = wr_n_q;

endmodule

// File: tb/tb_w5300_bus_ctrl.sv
// Directed bench for w5300_bus_ctrl with default timing parameters.
// A negedge monitor accumulates bus statistics; the initial block drives steps and checks.
module tb_w5300_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqValid;
  logic        reqReady;
  logic        reqOp;
  logic [9:0]  reqAddr;
  logic [15:0] reqWdata;
  logic        rspValid;
  logic [15:0] rspRdata;
  logic        rspErr;
  logic        busy;
  logic [9:0]  w5300Addr;
  logic [15:0] w5300DataOut;
  logic        w5300DataOe;
  logic [15:0] w5300DataIn;
  logic        w5300CsN;
  logic        w5300RdN;
  logic        w5300WrN;
  logic [15:0] rd_model;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Bus model: drives the chip's data only while RDn is low.
  assign w5300DataIn = (!w5300RdN) ? rd_model : 16'hDEAD;

  w5300_bus_ctrl dut (
    .clk(clk), .rst(rst),
    .reqValid(reqValid), .reqReady(reqReady), .reqOp(reqOp),
    .reqAddr(reqAddr), .reqWdata(reqWdata),
    .rspValid(rspValid), .rspRdata(rspRdata), .rspErr(rspErr), .busy(busy),
    .w5300Addr(w5300Addr), .w5300DataOut(w5300DataOut), .w5300DataOe(w5300DataOe),
    .w5300DataIn(w5300DataIn), .w5300CsN(w5300CsN), .w5300RdN(w5300RdN), .w5300WrN(w5300WrN)
  );

  // Monotonic statistics sampled mid-cycle.
  int          cyc = 0, acc_cnt = 0, last_acc = 0, rsp_cnt = 0, rsp_cyc = 0;
  int          cs_low = 0, wr_low = 0, rd_low = 0, overlap = 0, oe_rd = 0, oe_cs = 0;
  int          cs_rise = 0, last_gap = 0;
  logic        cs_prev = 1'b1;
  logic [15:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        hold_oe = 1'b0;
  logic [9:0]  strobe_addr = '0;
  logic [15:0] strobe_dout = '0;

  always @(negedge clk) begin
    cyc++;
    if (reqValid && reqReady) begin acc_cnt++; last_acc = cyc; end
    if (!w5300CsN) cs_low++;
    if (!w5300WrN) wr_low++;
    if (!w5300RdN) rd_low++;
    if (!w5300RdN && !w5300WrN) overlap++;
    if (!w5300RdN && w5300DataOe) oe_rd++;
    if (!w5300CsN && w5300DataOe) oe_cs++;
    if (!w5300CsN && cs_prev) last_gap = cyc - cs_rise;
    if (w5300CsN && !cs_prev) cs_rise = cyc;
    cs_prev = w5300CsN;
    if (!w5300WrN || !w5300RdN) begin strobe_addr = w5300Addr; strobe_dout = w5300DataOut; end
    if (rspValid) begin
      rsp_cnt++; rsp_cyc = cyc; rsp_data = rspRdata; rsp_err = rspErr; hold_oe = w5300DataOe;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Offers one request and returns 1 ns after the accepting edge.
  task automatic issue(input logic op, input logic [9:0] a, input logic [15:0] d);
    int base;
    base = acc_cnt;
    reqValid = 1'b1; reqOp = op; reqAddr = a; reqWdata = d;
    for (int i = 0; i < 50 && acc_cnt == base; i++) @(posedge clk);
    #1;
    reqValid = 1'b0;
    check("accept", acc_cnt, base + 1);
  endtask

  task automatic wait_rsp(input int base);
    for (int i = 0; i < 40 && rsp_cnt == base; i++) @(posedge clk);
    #1;
    check("rsp_seen", rsp_cnt, base + 1);
  endtask

  int c0, w0, r0, o0, rb, a0, acc1;

  initial begin
    rst = 1'b1; reqValid = 1'b0; reqOp = 1'b0; reqAddr = '0; reqWdata = '0; rd_model = '0;

    // 1. reset state and first-ready timing
    tick(5);
    check("rst_csn", w5300CsN, 1);
    check("rst_rdn", w5300RdN, 1);
    check("rst_wrn", w5300WrN, 1);
    check("rst_oe", w5300DataOe, 0);
    check("rst_rspvalid", rspValid, 0);
    check("rst_ready", reqReady, 0);
    check("rst_busy", busy, 0);
    check("rst_addr", w5300Addr, 0);
    rst = 1'b0;
    tick(1);
    check("ready_after_release", reqReady, 1);

    // 2. write 0x0008 to SHAR0 (0x008)
    c0 = cs_low; w0 = wr_low; r0 = rd_low; o0 = oe_cs; rb = rsp_cnt;
    issue(1'b0, 10'h008, 16'h0008);
    wait_rsp(rb);
    tick(4);
    check("wr_cs_low", cs_low - c0, 8);
    check("wr_wrn_low", wr_low - w0, 6);
    check("wr_rdn_low", rd_low - r0, 0);
    check("wr_oe_cycles", oe_cs - o0, 8);
    check("wr_latency", rsp_cyc - last_acc, 8);
    check("wr_pulse_len", rsp_cnt - rb, 1);
    check("wr_pin_addr", strobe_addr, 10'h008);
    check("wr_pin_data", strobe_dout, 16'h0008);
    check("wr_hold_oe", hold_oe, 1);
    check("wr_rdata", rsp_data, 0);
    check("wr_err", rsp_err, 0);

    // 3. read IDR (0x0fe), chip returns 0x5300
    rd_model = 16'h5300;
    c0 = cs_low; w0 = wr_low; r0 = rd_low; o0 = oe_cs; rb = rsp_cnt;
    issue(1'b1, 10'h0fe, 16'hFFFF);
    wait_rsp(rb);
    tick(4);
    check("rd_rdn_low", rd_low - r0, 7);
    check("rd_wrn_low", wr_low - w0, 0);
    check("rd_cs_low", cs_low - c0, 9);
    check("rd_oe_cycles", oe_cs - o0, 0);
    check("rd_latency", rsp_cyc - last_acc, 9);
    check("rd_pin_addr", strobe_addr, 10'h0fe);
    check("rd_data", rsp_data, 16'h5300);
    check("rd_hold_oe", hold_oe, 0);

    // 4. back-to-back with reqValid held high
    a0 = acc_cnt; w0 = wr_low; r0 = rd_low; rb = rsp_cnt;
    reqValid = 1'b1; reqOp = 1'b0; reqAddr = 10'h000; reqWdata = 16'h0080;
    for (int i = 0; i < 50 && acc_cnt == a0; i++) @(posedge clk);
    #1;
    acc1 = last_acc;
    reqOp = 1'b1; reqAddr = 10'h0fe; reqWdata = 16'h0000;
    for (int i = 0; i < 50 && acc_cnt == a0 + 1; i++) @(posedge clk);
    #1;
    reqValid = 1'b0;
    check("b2b_accepts", acc_cnt - a0, 2);
    check("b2b_spacing", last_acc - acc1, 12);
    wait_rsp(rb + 1);
    tick(4);
    check("b2b_cs_gap", last_gap, 4);
    check("b2b_wrn_low", wr_low - w0, 6);
    check("b2b_rdn_low", rd_low - r0, 7);
    check("b2b_rd_data", rsp_data, 16'h5300);

    // 5. async reset during the third RDn-low cycle
    rb = rsp_cnt;
    issue(1'b1, 10'h0fe, 16'h0000);
    tick(3);
    check("rst_mid_rdn_before", w5300RdN, 0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rdn", w5300RdN, 1);
    check("rst_mid_csn", w5300CsN, 1);
    check("rst_mid_oe", w5300DataOe, 0);
    tick(2);
    rst = 1'b0;
    tick(1);
    check("rst_mid_ready", reqReady, 1);
    tick(12);
    check("rst_mid_no_rsp", rsp_cnt, rb);
    rd_model = 16'h1234;
    issue(1'b1, 10'h0a0, 16'h0000);
    wait_rsp(rb);
    tick(4);
    check("post_rst_data", rsp_data, 16'h1234);
    check("post_rst_latency", rsp_cyc - last_acc, 9);

    // 6. odd address
    rd_model = 16'hBEEF;
    c0 = cs_low; r0 = rd_low; rb = rsp_cnt;
    issue(1'b1, 10'h001, 16'h0000);
    wait_rsp(rb);
    tick(4);
`ifdef W5300_ADDR_CHECK_EN
    check("odd_cs_low", cs_low - c0, 0);
    check("odd_rdn_low", rd_low - r0, 0);
    check("odd_latency", rsp_cyc - last_acc, 1);
    check("odd_err", rsp_err, 1);
    check("odd_data", rsp_data, 0);
`else
    check("odd_cs_low", cs_low - c0, 9);
    check("odd_rdn_low", rd_low - r0, 7);
    check("odd_latency", rsp_cyc - last_acc, 9);
    check("odd_err", rsp_err, 0);
    check("odd_data", rsp_data, 16'hBEEF);
    check("odd_pin_addr", strobe_addr, 10'h001);
`endif

    // Global bus invariants over the whole run
    check("strobe_overlap", overlap, 0);
    check("oe_during_rd", oe_rd, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
